// File: rtl/vga_text_memory_arbiter.sv
// Shares the single-port text RAM between the VGA character fetch (always wins),
// a small CPU write FIFO drained in spare cycles, and a sequenced CPU read path.
module vga_text_memory_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               video_request,
    input  logic [ADDRESS_WIDTH-1:0]           video_address,
    output logic [DATA_WIDTH-1:0]              video_data,
    output logic                               video_data_valid,
    input  logic                               cpu_write_request,
    input  logic [ADDRESS_WIDTH-1:0]           cpu_write_address,
    input  logic [DATA_WIDTH-1:0]              cpu_write_data,
    output logic                               cpu_write_ready,
    input  logic                               cpu_read_request,
    input  logic [ADDRESS_WIDTH-1:0]           cpu_read_address,
    output logic                               cpu_read_busy,
    output logic [DATA_WIDTH-1:0]              cpu_read_data,
    output logic                               cpu_read_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               memory_enable,
    output logic                               memory_write_enable,
    output logic [ADDRESS_WIDTH-1:0]           memory_address,
    output logic [DATA_WIDTH-1:0]              memory_write_data,
    input  logic [DATA_WIDTH-1:0]              memory_read_data
);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        READ_IDLE,
        READ_PENDING,
        READ_ISSUED,
        READ_DONE
    } read_state_t;

    read_state_t              read_state;
    logic [ADDRESS_WIDTH-1:0] fifo_address [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data    [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     write_pointer;
    logic [PTR_WIDTH-1:0]     read_pointer;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic                     video_access;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     read_issue;

    // Video is masked during reset so the RAM port stays idle while reset_n is low.
    assign video_access    = reset_n && video_request;
    assign fifo_empty      = (fifo_level == '0);
    assign cpu_write_ready = (fifo_level < FULL_LEVEL) && (read_state == READ_IDLE);
    assign cpu_read_busy   = (read_state != READ_IDLE);
    assign fifo_push       = cpu_write_request && cpu_write_ready;
    assign read_issue      = (read_state == READ_PENDING) && fifo_empty && !video_access;
    assign fifo_pop        = !video_access && !read_issue && !fifo_empty;
    assign video_data      = memory_read_data;

    always_comb begin
        memory_enable       = video_access || read_issue || fifo_pop;
        memory_write_enable = fifo_pop;
        memory_write_data   = fifo_data[read_pointer];
        if (video_access) begin
            memory_address = video_address;
        end else if (read_issue) begin
            memory_address = read_address;
        end else begin
            memory_address = fifo_address[read_pointer];
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_address[write_pointer] <= cpu_write_address;
            fifo_data[write_pointer]    <= cpu_write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            fifo_level    <= '0;
        end else begin
            if (fifo_push) begin
                write_pointer <= write_pointer + PTR_WIDTH'(1);
            end
            if (fifo_pop) begin
                read_pointer <= read_pointer + PTR_WIDTH'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_level <= fifo_level + LEVEL_WIDTH'(1);
            end else if (!fifo_push && fifo_pop) begin
                fifo_level <= fifo_level - LEVEL_WIDTH'(1);
            end
        end
    end

    // Read sequencer; pushes are held off outside READ_IDLE so older writes land first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_state       <= READ_IDLE;
            read_address     <= '0;
            cpu_read_data    <= '0;
            cpu_read_valid   <= 1'b0;
            video_data_valid <= 1'b0;
        end else begin
            video_data_valid <= video_request;
            cpu_read_valid   <= 1'b0;
            case (read_state)
                READ_IDLE: begin
                    if (cpu_read_request) begin
                        read_address <= cpu_read_address;
                        read_state   <= READ_PENDING;
                    end
                end
                READ_PENDING: begin
                    if (read_issue) begin
                        read_state <= READ_ISSUED;
                    end
                end
                READ_ISSUED: begin
                    cpu_read_data  <= memory_read_data;
                    cpu_read_valid <= 1'b1;
                    read_state     <= READ_DONE;
                end
                READ_DONE: begin
                    read_state <= READ_IDLE;
                end
                default: begin
                    read_state <= READ_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_text_memory_arbiter.sv
// Randomized bench for vga_text_memory_arbiter: a queue-based model of the arbiter
// plus a RAM model, with directed scenarios pinned by literal expectations.
module tb_vga_text_memory_arbiter;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          video_request;
    logic [AW-1:0] video_address;
    logic [DW-1:0] video_data;
    logic          video_data_valid;
    logic          cpu_write_request;
    logic [AW-1:0] cpu_write_address;
    logic [DW-1:0] cpu_write_data;
    logic          cpu_write_ready;
    logic          cpu_read_request;
    logic [AW-1:0] cpu_read_address;
    logic          cpu_read_busy;
    logic [DW-1:0] cpu_read_data;
    logic          cpu_read_valid;
    logic [LW-1:0] fifo_level;
    logic          memory_enable;
    logic          memory_write_enable;
    logic [AW-1:0] memory_address;
    logic [DW-1:0] memory_write_data;
    logic [DW-1:0] memory_read_data = '0;

    always #5 clk = ~clk;

    vga_text_memory_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .video_request      (video_request),
        .video_address      (video_address),
        .video_data         (video_data),
        .video_data_valid   (video_data_valid),
        .cpu_write_request  (cpu_write_request),
        .cpu_write_address  (cpu_write_address),
        .cpu_write_data     (cpu_write_data),
        .cpu_write_ready    (cpu_write_ready),
        .cpu_read_request   (cpu_read_request),
        .cpu_read_address   (cpu_read_address),
        .cpu_read_busy      (cpu_read_busy),
        .cpu_read_data      (cpu_read_data),
        .cpu_read_valid     (cpu_read_valid),
        .fifo_level         (fifo_level),
        .memory_enable      (memory_enable),
        .memory_write_enable(memory_write_enable),
        .memory_address     (memory_address),
        .memory_write_data  (memory_write_data),
        .memory_read_data   (memory_read_data)
    );

    logic [DW-1:0] ram       [0:4095];
    logic [DW-1:0] model_ram [0:4095];

    // Synchronous single-port RAM seen by the DUT.
    always @(posedge clk) begin
        if (memory_enable) begin
            if (memory_write_enable) ram[memory_address] <= memory_write_data;
            else                     memory_read_data <= ram[memory_address];
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } write_entry_t;

    write_entry_t  wq[$];
    bit            read_wait;
    logic [AW-1:0] read_addr;
    int            issue_cycle = -1;
    logic [DW-1:0] captured;
    logic [DW-1:0] exp_rd_data;
    bit            prev_video;
    logic [DW-1:0] prev_video_data;
    int            cycle = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Model: pending writes as a queue, reads as "waiting" plus the cycle they were issued.
    task automatic model_step();
        bit exp_rvalid, busy, ready, issue, drain;
        cycle++;
        if (!reset_n) begin
            wq.delete();
            read_wait   = 0;
            issue_cycle = -1;
            prev_video  = 0;
            exp_rd_data = '0;
            check_output("rst_mem_en", 32'(memory_enable), 32'(0));
            check_output("rst_level", 32'(fifo_level), 32'(0));
            check_output("rst_ready", 32'(cpu_write_ready), 32'(1));
            check_output("rst_busy", 32'(cpu_read_busy), 32'(0));
            check_output("rst_vvalid", 32'(video_data_valid), 32'(0));
            check_output("rst_rvalid", 32'(cpu_read_valid), 32'(0));
            check_output("rst_rdata", 32'(cpu_read_data), 32'(0));
            return;
        end
        exp_rvalid = (issue_cycle >= 0) && (cycle == issue_cycle + 2);
        if (exp_rvalid) exp_rd_data = captured;
        busy  = read_wait || ((issue_cycle >= 0) && (cycle == issue_cycle + 1 || cycle == issue_cycle + 2));
        ready = (wq.size() < DEPTH) && !busy;
        issue = read_wait && (wq.size() == 0) && !video_request;
        drain = !video_request && !issue && (wq.size() != 0);

        check_output("level", 32'(fifo_level), 32'(wq.size()));
        check_output("ready", 32'(cpu_write_ready), 32'(ready));
        check_output("busy", 32'(cpu_read_busy), 32'(busy));
        check_output("rvalid", 32'(cpu_read_valid), 32'(exp_rvalid));
        check_output("rdata", 32'(cpu_read_data), 32'(exp_rd_data));
        check_output("vvalid", 32'(video_data_valid), 32'(prev_video));
        if (prev_video) check_output("vdata", 32'(video_data), 32'(prev_video_data));
        check_output("mem_en", 32'(memory_enable), 32'(video_request || issue || drain));
        check_output("mem_we", 32'(memory_write_enable), 32'(drain));
        if (video_request)  check_output("mem_addr_video", 32'(memory_address), 32'(video_address));
        else if (issue)     check_output("mem_addr_read", 32'(memory_address), 32'(read_addr));
        else if (drain) begin
            check_output("mem_addr_write", 32'(memory_address), 32'(wq[0].addr));
            check_output("mem_wdata", 32'(memory_write_data), 32'(wq[0].data));
        end

        if (video_request) prev_video_data = model_ram[video_address];
        prev_video = video_request;
        if (drain) begin
            model_ram[wq[0].addr] = wq[0].data;
            void'(wq.pop_front());
        end
        if (issue) begin
            captured    = model_ram[read_addr];
            issue_cycle = cycle;
            read_wait   = 0;
        end
        if (cpu_write_request && ready) wq.push_back('{cpu_write_address, cpu_write_data});
        if (cpu_read_request && !busy) begin
            read_wait = 1;
            read_addr = cpu_read_address;
        end
    endtask

    always @(negedge clk) model_step();

    task automatic apply_stimulus(input bit vreq, input logic [AW-1:0] vaddr,
                                  input bit wreq, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                                  input bit rreq, input logic [AW-1:0] raddr);
        @(posedge clk);
        #1;
        video_request     = vreq;
        video_address     = vaddr;
        cpu_write_request = wreq;
        cpu_write_address = waddr;
        cpu_write_data    = wdata;
        cpu_read_request  = rreq;
        cpu_read_address  = raddr;
    endtask

    task automatic apply_idle();
        apply_stimulus(0, '0, 0, '0, '0, 0, '0);
    endtask

    task automatic apply_random(input int read_pct);
        apply_stimulus($urandom_range(0, 99) < 45, AW'($urandom_range(0, 15)),
                       $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), DW'($urandom),
                       $urandom_range(0, 99) < read_pct, AW'($urandom_range(0, 15)));
    endtask

    initial begin
        reset_n = 0;
        video_request = 0; video_address = '0;
        cpu_write_request = 0; cpu_write_address = '0; cpu_write_data = '0;
        cpu_read_request = 0; cpu_read_address = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]       = DW'($urandom);
            model_ram[i] = ram[i];
        end
        ram[16]       = 8'h41;
        model_ram[16] = 8'h41;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            apply_random(50);
            @(negedge clk);
            check_output("lit_rst_mem_en", 32'(memory_enable), 32'(0));
            check_output("lit_rst_ready", 32'(cpu_write_ready), 32'(1));
        end
        apply_idle();
        reset_n = 1;

        // Video fetch of 0x010.
        apply_stimulus(1, 12'h010, 0, '0, '0, 0, '0);
        @(negedge clk);
        check_output("lit_video_we", 32'(memory_write_enable), 32'(0));
        apply_idle();
        @(negedge clk);
        check_output("lit_video_valid", 32'(video_data_valid), 32'(1));
        check_output("lit_video_data", 32'(video_data), 32'(8'h41));

        // Fill FIFO under continuous video, then drain in order.
        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(1, AW'($urandom_range(32, 63)), 1, AW'(k), DW'(8'h10 + k), 0, '0);
            @(negedge clk);
            check_output("lit_fill_we", 32'(memory_write_enable), 32'(0));
        end
        apply_stimulus(1, 12'h020, 0, '0, '0, 0, '0);
        @(negedge clk);
        check_output("lit_full_level", 32'(fifo_level), 32'(4));
        check_output("lit_full_ready", 32'(cpu_write_ready), 32'(0));
        for (int k = 0; k < 4; k++) begin
            apply_idle();
            @(negedge clk);
            check_output("lit_drain_we", 32'(memory_write_enable), 32'(1));
            check_output("lit_drain_addr", 32'(memory_address), 32'(k + 1));
            check_output("lit_drain_data", 32'(memory_write_data), 32'(8'h11 + k));
            check_output("lit_drain_level", 32'(fifo_level), 32'(4 - k));
        end
        apply_idle();
        @(negedge clk);
        check_output("lit_drained_level", 32'(fifo_level), 32'(0));

        // Same-cycle write and read of 0x123.
        apply_stimulus(0, '0, 1, 12'h123, 8'h5A, 1, 12'h123);
        @(negedge clk);
        check_output("lit_wr_rd_ready", 32'(cpu_write_ready), 32'(1));
        apply_idle();
        @(negedge clk);
        check_output("lit_wr_first_we", 32'(memory_write_enable), 32'(1));
        check_output("lit_wr_first_addr", 32'(memory_address), 32'(12'h123));
        apply_idle();
        @(negedge clk);
        check_output("lit_rd_issue_en", 32'(memory_enable), 32'(1));
        check_output("lit_rd_issue_we", 32'(memory_write_enable), 32'(0));
        apply_idle();
        @(negedge clk);
        check_output("lit_rd_wait_valid", 32'(cpu_read_valid), 32'(0));
        apply_idle();
        @(negedge clk);
        check_output("lit_rd_valid", 32'(cpu_read_valid), 32'(1));
        check_output("lit_rd_data", 32'(cpu_read_data), 32'(8'h5A));
        apply_idle();
        @(negedge clk);
        check_output("lit_rd_valid_drop", 32'(cpu_read_valid), 32'(0));
        check_output("lit_rd_data_held", 32'(cpu_read_data), 32'(8'h5A));

        // Pending read behind two writes while video toggles.
        apply_stimulus(1, 12'h040, 1, 12'h200, 8'h77, 0, '0);
        apply_stimulus(1, 12'h041, 1, 12'h201, 8'h78, 1, 12'h200);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(i % 2 == 1, AW'(12'h050 + i), 1, 12'h3FF, 8'hEE, 0, '0);
            @(negedge clk);
            check_output("lit_pend_ready", 32'(cpu_write_ready), 32'(0));
            if (i % 2 == 1) check_output("lit_pend_video_addr", 32'(memory_address), 32'(12'h050 + i));
            if (i == 4) check_output("lit_pend_issue_addr", 32'(memory_address), 32'(12'h200));
            if (i == 6) check_output("lit_pend_rdata", 32'(cpu_read_data), 32'(8'h77));
        end
        apply_idle();

        // Reset while a read is pending with two writes queued.
        apply_stimulus(1, 12'h060, 1, 12'h300, 8'hAA, 0, '0);
        apply_stimulus(1, 12'h061, 1, 12'h301, 8'hBB, 1, 12'h300);
        apply_stimulus(1, 12'h062, 0, '0, '0, 0, '0);
        @(negedge clk);
        check_output("lit_prerst_level", 32'(fifo_level), 32'(2));
        apply_idle();
        reset_n = 0;
        @(negedge clk);
        check_output("lit_midrst_level", 32'(fifo_level), 32'(0));
        apply_idle();
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            apply_idle();
            @(negedge clk);
            check_output("lit_postrst_we", 32'(memory_write_enable), 32'(0));
            check_output("lit_postrst_rvalid", 32'(cpu_read_valid), 32'(0));
        end

        // Reset while a read is in flight.
        apply_stimulus(0, '0, 0, '0, '0, 1, 12'h123);
        apply_idle();
        @(negedge clk);
        check_output("lit_inflight_issue", 32'(memory_address), 32'(12'h123));
        apply_idle();
        reset_n = 0;
        apply_idle();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            apply_idle();
            @(negedge clk);
            check_output("lit_inflight_rvalid", 32'(cpu_read_valid), 32'(0));
            check_output("lit_inflight_rdata", 32'(cpu_read_data), 32'(0));
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            apply_random(20);
            reset_n = ($urandom_range(0, 399) != 0);
        end
        apply_idle();
        reset_n = 1;
        repeat (10) apply_idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
